// File: rtl/adder_result_accumulator_if.sv
// adder_result_accumulator_if
//
// Bundles the input (adder result) and output (frame total) handshakes of
// adder_result_accumulator. ACC_W must match the ACC_W of the accumulator
// instance that the interface is connected to.
//
// Handshake semantics: a transfer happens on the rising clock edge where
// valid and ready are both high. The source must hold valid and its payload
// stable until that edge. The sink's ready does not depend combinationally
// on valid.
//
// Signals:
//   start      : single-cycle frame start request (driver -> accumulator)
//   in_valid   : sum/cout carry a valid adder result (driver -> accumulator)
//   in_ready   : accumulator can take a result this cycle
//   sum, cout  : adder result, {cout,sum} is 0..15
//   out_valid  : frame total available on acc_out
//   out_ready  : downstream takes the frame total
//   acc_out    : frame total modulo 2^ACC_W
//   ovf        : sticky wrap flag for the current frame
//   busy       : frame in progress or waiting to be taken
//   sample_cnt : results accepted in the current frame
//
// Modports:
//   master : the adder/scoreboard side that drives the accumulator
//   slave  : the accumulator itself
interface adder_result_accumulator_if #(
    parameter int ACC_W = 8
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       sum;
    logic             cout;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             busy;
    logic [7:0]       sample_cnt;

    modport master (
        output start, in_valid, sum, cout, out_ready,
        input  in_ready, out_valid, acc_out, ovf, busy, sample_cnt
    );

    modport slave (
        input  start, in_valid, sum, cout, out_ready,
        output in_ready, out_valid, acc_out, ovf, busy, sample_cnt
    );
endinterface

// File: rtl/adder_result_accumulator.sv
// adder_result_accumulator
//
// Sums FRAME_LEN results of a 3-bit full adder ({cout,sum}, 0..15) into an
// ACC_W-bit accumulator and offers the frame total on a valid/ready output.
// A wrap of the accumulator during a frame sets a sticky ovf flag that is
// only cleared by the next frame start (or reset).
//
// Parameters:
//   ACC_W     : accumulator width, legal 5..16
//   FRAME_LEN : results per frame, legal 1..255
//
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : slave side of adder_result_accumulator_if (handshakes,
//               frame total, ovf, busy, sample_cnt)
//   state_dbg : encoded FSM state (0 IDLE, 1 ACCUM, 2 DONE)
module adder_result_accumulator #(
    parameter int ACC_W     = 8,
    parameter int FRAME_LEN = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    adder_result_accumulator_if.slave   bus,
    output logic [1:0]                  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Count value held by the transfer that completes the frame.
    localparam logic [7:0] LAST_CNT = 8'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic             ovf_q;
    logic [7:0]       cnt_q;

    logic             xfer;
    logic             last_xfer;
    logic             start_frame;
    logic [ACC_W:0]   add_full;   // one extra bit to catch the carry-out

    // in_ready is decoded from state only, so the transfer term carries no
    // combinational path from in_valid to in_ready.
    assign xfer        = (state_q == ACCUM) && bus.in_valid;
    assign last_xfer   = xfer && (cnt_q == LAST_CNT);
    assign start_frame = (state_q == IDLE) && bus.start;
    assign add_full    = {1'b0, acc_q} + {{(ACC_W - 3){1'b0}}, bus.cout, bus.sum};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b1;
                if (last_xfer) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                // start is deliberately not looked at here: leaving DONE
                // always lands in IDLE, even if start is high this cycle.
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: cleared by a start in IDLE, updated on each transfer, and
    // otherwise held so the last frame total stays visible in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_frame) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else if (xfer) begin
            acc_q <= add_full[ACC_W-1:0];
            cnt_q <= cnt_q + 8'd1;
            if (add_full[ACC_W]) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.acc_out    = acc_q;
    assign bus.ovf        = ovf_q;
    assign bus.sample_cnt = cnt_q;
    assign state_dbg      = state_q;

endmodule

// File: doc/adder_result_accumulator.md
# adder_result_accumulator

Downstream consumer of the 3-bit full adder. Each cycle it accepts one adder result, which is the 4-bit value {cout, sum[2:0]} in the range 0..15. It sums FRAME_LEN results into a wider accumulator and presents the frame total on a valid/ready output handshake. It sits between the adder and the checker/scoreboard logic, turning per-cycle adder results into per-frame totals with sticky overflow detection.

## Interface
Parameters:
- ACC_W, default 8: accumulator width in bits; legal range 5..16.
- FRAME_LEN, default 4: number of adder results per frame; legal range 1..255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: single-cycle frame start request; sampled only in IDLE.
- in_valid, input, 1: sum/cout carry a valid adder result.
- in_ready, output, 1: block can accept a result this cycle.
- sum, input, 3: adder sum output.
- cout, input, 1: adder carry-out.
- out_valid, output, 1: frame total is available on acc_out.
- out_ready, input, 1: downstream accepts the frame total.
- acc_out, output, ACC_W: accumulated frame total, modulo 2^ACC_W.
- ovf, output, 1: sticky flag; set if the accumulator wrapped during the current frame.
- busy, output, 1: high in ACCUM and DONE.
- sample_cnt, output, 8: number of results accepted in the current frame.

## Operation
- FSM states are IDLE, ACCUM and DONE. The state is registered. in_ready, out_valid and busy decode from the state only, with no combinational path from inputs.
- **IDLE:**
  - in_ready=0, out_valid=0, busy=0.
  - When start=1, the next state is ACCUM, and acc, sample_cnt and ovf clear to 0 on the same edge.
  - acc_out keeps showing the previous frame total until a start clears it.
- **ACCUM:**
  - in_ready=1. A transfer occurs when in_valid && in_ready.
  - On each transfer, acc <= acc + zero_extend({cout,sum}) and sample_cnt <= sample_cnt + 1.
  - If the ACC_W-bit add carries out, acc keeps the low ACC_W bits and ovf <= 1. ovf is never cleared inside a frame.
  - in_valid=0 cycles are bubbles: no state change.
  - The transfer that makes sample_cnt reach FRAME_LEN moves the FSM to DONE.
- **DONE:**
  - out_valid=1, in_ready=0. acc_out, ovf and sample_cnt are held stable.
  - When out_valid && out_ready, the FSM returns to IDLE; acc_out, ovf and sample_cnt keep their values.
- **Ignored inputs:**
  - start is ignored in ACCUM and DONE; a running frame is never restarted.
  - start and out_ready both high in DONE gives IDLE only; start is not sampled in that same cycle.
  - sum and cout are ignored whenever no transfer occurs.
- Arithmetic is unsigned. The {cout,sum} operand is 4 bits, zero-extended to ACC_W.

## Timing
- Reset (asynchronous assert, any state) forces:
  - state=IDLE,
  - acc_out=0, ovf=0, sample_cnt=0,
  - in_ready=0, out_valid=0, busy=0.
  
  Reset mid-frame discards the partial total. Deassertion is synchronous to clk by the surrounding reset logic.
- start is seen at edge N; in_ready=1 from cycle N+1.
- Throughput is one result per cycle in ACCUM.
- The last transfer at edge M gives out_valid=1 in cycle M+1 with the final acc_out.
- Minimum frame latency is start + FRAME_LEN + 1 cycles to out_valid.
- out_valid stays high with acc_out stable for any number of out_ready=0 cycles.
- With FRAME_LEN=1, the first transfer goes directly to DONE.

## Test plan
- **Basic frame** (ACC_W=8, FRAME_LEN=4): start, then back-to-back {cout,sum} = {0,5}, {1,2}, {0,7}, {1,7}. Required: out_valid one cycle after the 4th transfer, acc_out=37 (0x25), ovf=0, sample_cnt=4.
- **Overflow** (ACC_W=5, FRAME_LEN=4): four transfers of {1,7}=15. Required: acc_out=28 (60 mod 32), ovf=1. ovf stays 1 until the next start, then clears.
- **Bubbles and backpressure** (default parameters): in_valid toggling 1,0,0,1,1,0,1 with operand 3 each valid cycle. Required:
  - acc_out=12 after 4 transfers;
  - with out_ready held 0 for 3 cycles, out_valid stays 1 and acc_out stays 12;
  - out_ready=1 returns the FSM to IDLE; acc_out stays 12.
- **Ignored start:** pulse start in the middle of ACCUM and again in DONE together with out_ready=1. Required: the frame total is unaffected, and the FSM ends in IDLE, not ACCUM.
- **Reset mid-frame:** assert rst_n=0 after 2 of 4 transfers, asynchronously and between clock edges. Required: all outputs go to 0 immediately. The next start plus 4 transfers of 1 gives acc_out=4.
- **FRAME_LEN=1:** start, then a single transfer of {1,0}=8. Required: out_valid in the next cycle, acc_out=8, sample_cnt=1.
